// File: rtl/cpu_regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// cpu_regfile_scoreboard_if
//
// Purpose:
//   Bundles the decode/execute-facing signals of the CPU register file into
//   one interface. Clock and reset stay as plain ports on the register file.
//
// Modports:
//   master : the pipeline side (decode/writeback) that drives writes,
//            reservations, read selects and PC control, and observes the
//            read data, valid flags, PC and scoreboard.
//   slave  : the register file itself.
//
// Signals:
//   WR_EN, WR_SEL, REG_INPUT_BUS     write port
//   RSV_EN, RSV_SEL                  scoreboard reserve port
//   OP0/OP1_REG_OUT_SEL              read selects
//   OP0/OP1_OUT_BUS, OP0/OP1_VALID   read data and operand-ready flags
//   PC_REG_EN, PC_LOAD, PC_IN_BUS    PC control
//   PC_BUS                           current PC
//   PENDING_BUS                      scoreboard bits, one per GPR
// -----------------------------------------------------------------------------
interface cpu_regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 15
);
    logic                  WR_EN;
    logic [ADDR_WIDTH-1:0] WR_SEL;
    logic [DATA_WIDTH-1:0] REG_INPUT_BUS;

    logic                  RSV_EN;
    logic [ADDR_WIDTH-1:0] RSV_SEL;

    logic [ADDR_WIDTH-1:0] OP0_REG_OUT_SEL;
    logic [ADDR_WIDTH-1:0] OP1_REG_OUT_SEL;
    logic [DATA_WIDTH-1:0] OP0_OUT_BUS;
    logic [DATA_WIDTH-1:0] OP1_OUT_BUS;
    logic                  OP0_VALID;
    logic                  OP1_VALID;

    logic                  PC_REG_EN;
    logic                  PC_LOAD;
    logic [DATA_WIDTH-1:0] PC_IN_BUS;
    logic [DATA_WIDTH-1:0] PC_BUS;

    logic [NUM_REGS-1:0]   PENDING_BUS;

    modport master (
        output WR_EN, WR_SEL, REG_INPUT_BUS,
        output RSV_EN, RSV_SEL,
        output OP0_REG_OUT_SEL, OP1_REG_OUT_SEL,
        input  OP0_OUT_BUS, OP1_OUT_BUS, OP0_VALID, OP1_VALID,
        output PC_REG_EN, PC_LOAD, PC_IN_BUS,
        input  PC_BUS,
        input  PENDING_BUS
    );

    modport slave (
        input  WR_EN, WR_SEL, REG_INPUT_BUS,
        input  RSV_EN, RSV_SEL,
        input  OP0_REG_OUT_SEL, OP1_REG_OUT_SEL,
        output OP0_OUT_BUS, OP1_OUT_BUS, OP0_VALID, OP1_VALID,
        input  PC_REG_EN, PC_LOAD, PC_IN_BUS,
        output PC_BUS,
        output PENDING_BUS
    );
endinterface

// File: rtl/cpu_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// cpu_regfile_scoreboard
//
// Purpose:
//   General-purpose register file sitting between decode and execute:
//   NUM_REGS GPRs, two combinational read ports, one write port, a program
//   counter with auto-increment/load, and a per-register pending-write
//   scoreboard so decode can stall on operands not yet produced.
//
//   Select encoding (shared by read, write and reserve selects):
//     sel <  NUM_REGS          : GPR[sel]
//     NUM_REGS <= sel < PC_IDX : unimplemented, reads 0, always valid
//     sel == PC_IDX (all ones) : PC (read-only through the GPR ports)
//
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   ACLR  : asynchronous active-high reset (GPRs, scoreboard, PC)
//   bus   : cpu_regfile_scoreboard_if.slave -- write, reserve, read, PC and
//           scoreboard signals
//
// Configuration:
//   REGFILE_BYPASS_EN : when defined, a read that hits the register being
//   written this cycle returns REG_INPUT_BUS with VALID=1. Registered state is
//   the same with or without it.
// -----------------------------------------------------------------------------
module cpu_regfile_scoreboard #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    NUM_REGS   = 15,
    parameter int                    PC_INC     = 4,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
    input  logic                      CLK,
    input  logic                      ACLR,
    cpu_regfile_scoreboard_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] PC_IDX   = '1;
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(PC_INC);
    localparam int                    NUM_PORT = 2;

    // Architectural state
    logic [DATA_WIDTH-1:0] r_gpr [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic [DATA_WIDTH-1:0] r_pc;

    // Decoded per-register strobes and read-port plumbing
    logic [NUM_REGS-1:0]   w_wr_dec;
    logic [NUM_REGS-1:0]   w_rsv_dec;
    logic [NUM_REGS-1:0]   w_pending_next;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_rd_sel   [NUM_PORT];
    logic [DATA_WIDTH-1:0] w_rd_data  [NUM_PORT];
    logic                  w_rd_valid [NUM_PORT];

    // -------------------------------------------------------------------------
    // Select decode. Only indices below NUM_REGS get a strobe, so writes and
    // reservations to unimplemented slots or to PC_IDX fall away naturally.
    // The write strobe is masked by ACLR so the bypass path cannot leak write
    // data onto the read buses while the block is held in reset.
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wr_dec  = '0;
        w_rsv_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_dec[i]  = bus.WR_EN  && !ACLR && (bus.WR_SEL  == ADDR_WIDTH'(i));
            w_rsv_dec[i] = bus.RSV_EN && !ACLR && (bus.RSV_SEL == ADDR_WIDTH'(i));
        end
    end

    // A writeback clears its bit, a reservation sets it; applying the set
    // after the clear makes a same-edge reservation win over the older
    // writeback to the same register.
    always_comb begin
        w_pending_next = (r_pending & ~w_wr_dec) | w_rsv_dec;
    end

    always_comb begin
        w_pc_next = r_pc;
        if (bus.PC_REG_EN) begin
            w_pc_next = bus.PC_LOAD ? bus.PC_IN_BUS : (r_pc + PC_STEP);
        end
    end

    // -------------------------------------------------------------------------
    // GPR array
    // -------------------------------------------------------------------------
    // NOTE: the GPR array is cleared on ACLR like any other register; that
    // forces flops rather than a RAM macro, which is intended for a register
    // file this small.
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_dec[i]) begin
                    r_gpr[i] <= bus.REG_INPUT_BUS;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard and PC
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            r_pending <= '0;
            r_pc      <= PC_RESET;
        end else begin
            r_pending <= w_pending_next;
            r_pc      <= w_pc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports (combinational, zero latency). Both ports share one mux
    // description; unimplemented selects fall through to 0 / valid.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rd_sel[0] = bus.OP0_REG_OUT_SEL;
        w_rd_sel[1] = bus.OP1_REG_OUT_SEL;
    end

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            w_rd_data[p]  = '0;
            w_rd_valid[p] = 1'b1;
            if (w_rd_sel[p] == PC_IDX) begin
                w_rd_data[p] = r_pc;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_rd_sel[p] == ADDR_WIDTH'(i)) begin
                    w_rd_data[p]  = r_gpr[i];
                    w_rd_valid[p] = ~r_pending[i];
`ifdef REGFILE_BYPASS_EN
                    // The value being written this cycle is the newest one and
                    // is by definition produced, so it overrides both the
                    // stored data and the pending bit.
                    if (w_wr_dec[i]) begin
                        w_rd_data[p]  = bus.REG_INPUT_BUS;
                        w_rd_valid[p] = 1'b1;
                    end
`else
                    // Stored value and pending bit are returned until the
                    // edge after the write.
`endif
                end
            end
        end
    end

    assign bus.OP0_OUT_BUS = w_rd_data[0];
    assign bus.OP1_OUT_BUS = w_rd_data[1];
    assign bus.OP0_VALID   = w_rd_valid[0];
    assign bus.OP1_VALID   = w_rd_valid[1];
    assign bus.PC_BUS      = r_pc;
    assign bus.PENDING_BUS = r_pending;

endmodule

// File: tb/tb_cpu_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_cpu_regfile_scoreboard
//
// Two register files are driven with identical stimulus: dut_a with the
// default NUM_REGS=15 and dut_b with NUM_REGS=8, so selects 8..14 exercise
// the unimplemented-register rules on dut_b. A behavioural model predicts
// the visible outputs for each cycle; predictions go into a queue per DUT
// and a monitor compares them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct packed {
        logic [31:0] op0;
        logic        v0;
        logic [31:0] op1;
        logic        v1;
        logic [31:0] pc;
        logic [14:0] pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    // Stimulus variables, shared by both DUTs
    logic          wr_en;
    logic [AW-1:0] wr_sel;
    logic [DW-1:0] wr_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_sel;
    logic [AW-1:0] op0_sel;
    logic [AW-1:0] op1_sel;
    logic          pc_en;
    logic          pc_load;
    logic [DW-1:0] pc_in;

    int n_checks = 0;
    int n_err    = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state, index 0 -> dut_a, 1 -> dut_b
    logic [31:0] m_gpr  [2][15];
    logic [14:0] m_pend [2];
    logic [31:0] m_pc   [2];

    always #5 clk = ~clk;

    cpu_regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(15)) if_a ();
    cpu_regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(8))  if_b ();

    assign if_a.WR_EN           = wr_en;
    assign if_a.WR_SEL          = wr_sel;
    assign if_a.REG_INPUT_BUS   = wr_data;
    assign if_a.RSV_EN          = rsv_en;
    assign if_a.RSV_SEL         = rsv_sel;
    assign if_a.OP0_REG_OUT_SEL = op0_sel;
    assign if_a.OP1_REG_OUT_SEL = op1_sel;
    assign if_a.PC_REG_EN       = pc_en;
    assign if_a.PC_LOAD         = pc_load;
    assign if_a.PC_IN_BUS       = pc_in;

    assign if_b.WR_EN           = wr_en;
    assign if_b.WR_SEL          = wr_sel;
    assign if_b.REG_INPUT_BUS   = wr_data;
    assign if_b.RSV_EN          = rsv_en;
    assign if_b.RSV_SEL         = rsv_sel;
    assign if_b.OP0_REG_OUT_SEL = op0_sel;
    assign if_b.OP1_REG_OUT_SEL = op1_sel;
    assign if_b.PC_REG_EN       = pc_en;
    assign if_b.PC_LOAD         = pc_load;
    assign if_b.PC_IN_BUS       = pc_in;

    cpu_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(15)) dut_a (
        .CLK  (clk),
        .ACLR (rst),
        .bus  (if_a.slave)
    );

    cpu_regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(8)) dut_b (
        .CLK  (clk),
        .ACLR (rst),
        .bus  (if_b.slave)
    );

    // ---------------------------------------------------------------- model
    function automatic int nregs(input int m);
        return (m == 0) ? 15 : 8;
    endfunction

    function automatic logic bypass_hit(input int m, input logic [AW-1:0] sel);
`ifdef REGFILE_BYPASS_EN
        return !rst && wr_en && (wr_sel == sel) && (int'(sel) < nregs(m));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_read(input int m, input logic [AW-1:0] sel);
        if (sel == 4'hF)              return m_pc[m];
        if (int'(sel) >= nregs(m))    return 32'h0;
        if (bypass_hit(m, sel))       return wr_data;
        return m_gpr[m][sel];
    endfunction

    function automatic logic m_valid(input int m, input logic [AW-1:0] sel);
        if (int'(sel) >= nregs(m))    return 1'b1;
        if (bypass_hit(m, sel))       return 1'b1;
        return !m_pend[m][sel];
    endfunction

    function automatic exp_t m_expect(input int m);
        exp_t e;
        e.op0  = m_read(m, op0_sel);
        e.v0   = m_valid(m, op0_sel);
        e.op1  = m_read(m, op1_sel);
        e.v1   = m_valid(m, op1_sel);
        e.pc   = m_pc[m];
        e.pend = m_pend[m];
        return e;
    endfunction

    task automatic m_reset(input int m);
        for (int i = 0; i < 15; i++) m_gpr[m][i] = 32'h0;
        m_pend[m] = '0;
        m_pc[m]   = 32'h0;
    endtask

    // One rising edge: writeback clears pending, then a reservation sets it.
    task automatic m_step(input int m);
        if (wr_en && int'(wr_sel) < nregs(m)) begin
            m_gpr[m][wr_sel]  = wr_data;
            m_pend[m][wr_sel] = 1'b0;
        end
        if (rsv_en && int'(rsv_sel) < nregs(m)) begin
            m_pend[m][rsv_sel] = 1'b1;
        end
        if (pc_en) begin
            m_pc[m] = pc_load ? pc_in : m_pc[m] + 32'd4;
        end
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic idle();
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        pc_en   = 1'b0;
        pc_load = 1'b0;
    endtask

    // Called shortly after a rising edge with this cycle's inputs set:
    // record the expected outputs for this cycle, then let the edge happen.
    task automatic apply();
        if (rst) begin
            m_reset(0);
            m_reset(1);
        end
        q_a.push_back(m_expect(0));
        q_b.push_back(m_expect(1));
        @(posedge clk);
        if (!rst) begin
            m_step(0);
            m_step(1);
        end
        #1;
    endtask

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e,
                       input logic [31:0] op0, input logic v0,
                       input logic [31:0] op1, input logic v1,
                       input logic [31:0] pc,  input logic [31:0] pend);
        check({tag, ".op0"},     op0,       e.op0);
        check({tag, ".op0_vld"}, 32'(v0),   32'(e.v0));
        check({tag, ".op1"},     op1,       e.op1);
        check({tag, ".op1_vld"}, 32'(v1),   32'(e.v1));
        check({tag, ".pc"},      pc,        e.pc);
        check({tag, ".pending"}, pend,      32'(e.pend));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("a", e, if_a.OP0_OUT_BUS, if_a.OP0_VALID, if_a.OP1_OUT_BUS,
                    if_a.OP1_VALID, if_a.PC_BUS, 32'(if_a.PENDING_BUS));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp("b", e, if_b.OP0_OUT_BUS, if_b.OP0_VALID, if_b.OP1_OUT_BUS,
                    if_b.OP1_VALID, if_b.PC_BUS, 32'(if_b.PENDING_BUS));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- sequence
    initial begin : stim
        rst = 1'b1;
        idle();
        wr_sel  = '0;
        wr_data = '0;
        rsv_sel = '0;
        pc_in   = '0;
        op0_sel = 4'd0;
        op1_sel = 4'd15;
        m_reset(0);
        m_reset(1);
        @(posedge clk);
        #1;

        // Reset state
        apply();
        apply();
        rst = 1'b0;

        // Write r3, read it back; PC through read port 1
        wr_en = 1'b1; wr_sel = 4'd3; wr_data = 32'hDEADBEEF; op0_sel = 4'd3;
        apply();
        idle(); op0_sel = 4'd3; op1_sel = 4'd15;
        apply();

        // Write to PC_IDX through the GPR port is ignored
        wr_en = 1'b1; wr_sel = 4'd15; wr_data = 32'h00001234;
        apply();
        idle();
        apply();

        // Reserve r5, then write it back
        rsv_en = 1'b1; rsv_sel = 4'd5; op0_sel = 4'd5;
        apply();
        idle();
        apply();
        wr_en = 1'b1; wr_sel = 4'd5; wr_data = 32'h0000A5A5;
        apply();
        idle();
        apply();

        // Reserve and write r5 on the same edge: reservation wins
        rsv_en = 1'b1; rsv_sel = 4'd5; wr_en = 1'b1; wr_sel = 4'd5; wr_data = 32'h00005555;
        apply();
        idle();
        apply();

        // PC: load near the top, increment wraps, load, hold
        pc_en = 1'b1; pc_load = 1'b1; pc_in = 32'hFFFFFFFC; op1_sel = 4'd15;
        apply();
        pc_load = 1'b0;
        apply();
        pc_load = 1'b1; pc_in = 32'h00000100;
        apply();
        idle();
        apply();
        apply();

        // Write-to-read behaviour on a pending register (r7: 0x11 -> 0x22)
        wr_en = 1'b1; wr_sel = 4'd7; wr_data = 32'h00000011;
        apply();
        idle(); rsv_en = 1'b1; rsv_sel = 4'd7;
        apply();
        idle(); wr_en = 1'b1; wr_sel = 4'd7; wr_data = 32'h00000022; op0_sel = 4'd7; op1_sel = 4'd7;
        apply();
        idle();
        apply();

        // Index 10: unimplemented on dut_b, a real register on dut_a
        wr_en = 1'b1; wr_sel = 4'd10; wr_data = 32'h00000BAD; op0_sel = 4'd10;
        apply();
        idle(); rsv_en = 1'b1; rsv_sel = 4'd10;
        apply();
        idle();
        apply();

        // Build pending=0x0005 and PC=0x40 (clear r5 and r10 at the same time)
        rsv_en = 1'b1; rsv_sel = 4'd0; wr_en = 1'b1; wr_sel = 4'd5; wr_data = 32'h0;
        apply();
        rsv_sel = 4'd2; wr_sel = 4'd10; pc_en = 1'b1; pc_load = 1'b1; pc_in = 32'h00000040;
        apply();
        idle(); op0_sel = 4'd0; op1_sel = 4'd2;
        apply();

        // Asynchronous reset asserted mid-cycle, checked before the next edge
        rst = 1'b1;
        apply();
        op1_sel = 4'd15;
        apply();
        rst = 1'b0;

        // Randomised traffic, with reads biased toward the written register
        for (int n = 0; n < 400; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_sel  = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rsv_en  = 1'($urandom_range(0, 1));
            rsv_sel = ($urandom_range(0, 3) == 0) ? wr_sel : 4'($urandom_range(0, 15));
            op0_sel = ($urandom_range(0, 3) == 0) ? wr_sel : 4'($urandom_range(0, 15));
            op1_sel = ($urandom_range(0, 3) == 0) ? rsv_sel : 4'($urandom_range(0, 15));
            pc_en   = 1'($urandom_range(0, 1));
            pc_load = ($urandom_range(0, 7) == 0);
            pc_in   = $urandom;
            rst     = ($urandom_range(0, 99) == 0);
            apply();
        end
        rst = 1'b0;
        idle();
        apply();

        // Let the monitor consume the last prediction
        @(negedge clk);
        #1;
        check("queue_drain", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
